// File: rtl/vid_timing.sv
// Raster timing generator for the pixel-clock domain.
// Free-running h/v counters feed registered sync, data-enable, coordinate and strobe decodes.
// A per-line prefetch request/acknowledge lets the framebuffer reader fill its line buffer
// during horizontal blanking. A request that is still open when its line starts is flagged
// by a sticky underflow bit.
module vid_timing #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 32,
   parameter int unsigned H_SYNC   = 64,
   parameter int unsigned H_BP     = 96,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 3,
   parameter int unsigned V_BP     = 48,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0,
   parameter int unsigned LEAD     = 128
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pll_locked,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic [10:0] x,
   output logic [9:0]  y,
   output logic        frame_start,
   output logic        line_start,
   output logic        line_req,
   output logic [9:0]  line_y,
   input  logic        line_ack,
   output logic        underflow
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
   localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
   localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] REQ_H  = 11'(H_TOTAL - LEAD);
   localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
   localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

   // Losing PLL lock is treated exactly like an external reset.
   logic srst;
   assign srst = rst | ~pll_locked;

   logic [10:0] h_cnt_q;
   logic [9:0]  v_cnt_q;
   logic        h_wrap;
   logic [9:0]  next_row;

   assign h_wrap   = (h_cnt_q == H_LAST);
   assign next_row = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;

   // Horizontal counter wraps each line; vertical counter steps on that wrap.
   always_ff @(posedge clk) begin
      if (srst) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else if (h_wrap) begin
         h_cnt_q <= '0;
         v_cnt_q <= next_row;
      end else begin
         h_cnt_q <= h_cnt_q + 11'd1;
      end
   end

   logic        hsync_q, vsync_q, de_q, frame_start_q, line_start_q;
   logic [10:0] x_q;
   logic [9:0]  y_q;

   // Registered decodes of the counters; all outputs share the same one-cycle latency.
   always_ff @(posedge clk) begin
      if (srst) begin
         hsync_q       <= ~HS_POL;
         vsync_q       <= ~VS_POL;
         de_q          <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
         frame_start_q <= 1'b0;
         line_start_q  <= 1'b0;
      end else begin
         hsync_q       <= (h_cnt_q >= HS_BEG && h_cnt_q < HS_END) ? HS_POL : ~HS_POL;
         vsync_q       <= (v_cnt_q >= VS_BEG && v_cnt_q < VS_END) ? VS_POL : ~VS_POL;
         de_q          <= (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
         x_q           <= h_cnt_q;
         y_q           <= v_cnt_q;
         frame_start_q <= (h_cnt_q == 11'd0) && (v_cnt_q == 10'd0);
         line_start_q  <= (h_cnt_q == 11'd0);
      end
   end

   logic       line_req_q, line_req_d;
   logic [9:0] line_y_q, line_y_d;
   logic       underflow_q, underflow_d;

   // Prefetch handshake: ack wins over the deadline when both land on the wrap cycle.
   // The trigger sits in blanking, after the deadline check, so requests never overlap.
   always_comb begin
      line_req_d  = line_req_q;
      line_y_d    = line_y_q;
      underflow_d = underflow_q;
      if (line_req_q) begin
         if (line_ack) begin
            line_req_d = 1'b0;
         end else if (h_cnt_q == 11'd0) begin
            line_req_d  = 1'b0;
            underflow_d = 1'b1;
         end
      end else if (h_cnt_q == REQ_H && next_row < V_ACT) begin
         line_req_d = 1'b1;
         line_y_d   = next_row;
      end
   end

   // Handshake state; a pending request is dropped silently on reset or lock loss.
   always_ff @(posedge clk) begin
      if (srst) begin
         line_req_q  <= 1'b0;
         line_y_q    <= '0;
         underflow_q <= 1'b0;
      end else begin
         line_req_q  <= line_req_d;
         line_y_q    <= line_y_d;
         underflow_q <= underflow_d;
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign de          = de_q;
   assign x           = x_q;
   assign y           = y_q;
   assign frame_start = frame_start_q;
   assign line_start  = line_start_q;
   assign line_req    = line_req_q;
   assign line_y      = line_y_q;
   assign underflow   = underflow_q;

endmodule

// File: tb/tb_vid_timing.sv
// Directed bench for vid_timing. Horizontal timing is the default 832-pixel line; the
// vertical timing is shortened (6 active, fp 2, sync 3, bp 3 -> 14 lines) so whole frames
// fit in a short run. vsync is low on lines 8..10, rows 0..5 are prefetched.
module tb_vid_timing;

   localparam int HT    = 832;
   localparam int VT    = 14;
   localparam int VA    = 6;
   localparam int FRAME = HT * VT;

   logic        clk = 1'b0;
   logic        rst, pll_locked, line_ack;
   logic        hsync, vsync, de, frame_start, line_start, line_req, underflow;
   logic [10:0] x;
   logic [9:0]  y, line_y;

   vid_timing #(
      .H_ACTIVE (640),
      .H_FP     (32),
      .H_SYNC   (64),
      .H_BP     (96),
      .V_ACTIVE (6),
      .V_FP     (2),
      .V_SYNC   (3),
      .V_BP     (3),
      .HS_POL   (1'b0),
      .VS_POL   (1'b0),
      .LEAD     (128)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pll_locked  (pll_locked),
      .hsync       (hsync),
      .vsync       (vsync),
      .de          (de),
      .x           (x),
      .y           (y),
      .frame_start (frame_start),
      .line_start  (line_start),
      .line_req    (line_req),
      .line_y      (line_y),
      .line_ack    (line_ack),
      .underflow   (underflow)
   );

   always #5 clk = ~clk;

   int   n_vec;
   int   n_bad;
   int   k;           // output-cycle index since frame origin
   int   mode;        // 0: ack 5 cycles after req, 1: ack in wrap cycle, 2: never ack
   int   mode_start;
   bit   exp_ufl;
   int   req_cnt;
   logic prev_req;

   task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s k=%0d observed=%0d required=%0d", tag, k, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s k=%0d observed=%b required=%b", tag, k, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      chk1({tag, ".hsync"}, hsync, 1'b1);
      chk1({tag, ".vsync"}, vsync, 1'b1);
      chk1({tag, ".de"}, de, 1'b0);
      chk1({tag, ".frame_start"}, frame_start, 1'b0);
      chk1({tag, ".line_start"}, line_start, 1'b0);
      chk1({tag, ".line_req"}, line_req, 1'b0);
      chk1({tag, ".underflow"}, underflow, 1'b0);
      chkn({tag, ".x"}, 32'(x), 32'd0);
      chkn({tag, ".y"}, 32'(y), 32'd0);
      chkn({tag, ".line_y"}, 32'(line_y), 32'd0);
   endtask

   // Check the current output cycle against the raster arithmetic, then drive line_ack.
   task automatic check_cycle();
      int xe, ye, nv;
      bit rl, req_e;
      xe = k % HT;
      ye = (k / HT) % VT;
      nv = (ye + 1) % VT;
      rl = (nv < VA);
      if (mode == 0) req_e = rl && xe >= 704 && xe <= 709;
      else           req_e = rl && xe >= 704;
      if (mode == 2 && xe == 0 && ye < VA && k > mode_start) exp_ufl = 1'b1;
      chkn("x", 32'(x), 32'(xe));
      chkn("y", 32'(y), 32'(ye));
      chk1("de", de, (xe < 640) && (ye < VA));
      chk1("hsync", hsync, !(xe >= 672 && xe < 736));
      chk1("vsync", vsync, !(ye >= 8 && ye < 11));
      chk1("frame_start", frame_start, (xe == 0) && (ye == 0));
      chk1("line_start", line_start, (xe == 0));
      chk1("line_req", line_req, req_e);
      chk1("underflow", underflow, exp_ufl);
      if (req_e) chkn("line_y", 32'(line_y), 32'(nv));
      if (line_req === 1'b1 && prev_req !== 1'b1) req_cnt++;
      prev_req = line_req;
      case (mode)
         0:       line_ack = (xe == 709) && rl;
         1:       line_ack = ((xe == 831) && rl) || (xe == 100);
         default: line_ack = 1'b0;
      endcase
   endtask

   task automatic scan(input int n);
      for (int i = 0; i < n; i++) begin
         check_cycle();
         @(negedge clk);
         k++;
      end
   endtask

   task automatic pll_drop(input string tag);
      pll_locked = 1'b0;
      line_ack   = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_reset(tag);
      end
      pll_locked = 1'b1;
      @(negedge clk);
      k        = 0;
      prev_req = 1'b0;
      exp_ufl  = 1'b0;
      chk1({tag, ".relock_frame_start"}, frame_start, 1'b1);
      chkn({tag, ".relock_x"}, 32'(x), 32'd0);
      chkn({tag, ".relock_y"}, 32'(y), 32'd0);
   endtask

   initial begin
      n_vec      = 0;
      n_bad      = 0;
      k          = 0;
      mode       = 0;
      mode_start = 0;
      exp_ufl    = 1'b0;
      req_cnt    = 0;
      prev_req   = 1'b0;
      rst        = 1'b1;
      pll_locked = 1'b1;
      line_ack   = 1'b0;
      repeat (3) @(negedge clk);
      check_reset("por");

      // Release: one cycle later the outputs show the frame origin.
      rst = 1'b0;
      @(negedge clk);
      k = 0;

      // Full frame with a prompt fetcher; row 0 is requested on the last line.
      mode = 0;
      mode_start = k;
      scan(FRAME);
      chkn("req_per_frame", 32'(req_cnt), 32'(VA));

      // Acks landing in the wrap cycle, plus a stray ack while idle; k=FRAME is the recurrence.
      mode = 1;
      mode_start = k;
      scan(3 * HT);

      // Fetcher goes silent: deadline misses, underflow sticks across frames.
      mode = 2;
      mode_start = k;
      scan(2 * FRAME);
      chk1("underflow_sticky", underflow, 1'b1);

      // rst clears the sticky flag.
      line_ack = 1'b0;
      rst      = 1'b1;
      @(negedge clk);
      check_reset("rst_clear");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      k          = 0;
      prev_req   = 1'b0;
      exp_ufl    = 1'b0;
      mode       = 0;
      mode_start = 0;

      // Lock loss mid-line while idle.
      scan(3 * HT + 300);
      chkn("pre_drop_x", 32'(x), 32'd300);
      chkn("pre_drop_y", 32'(y), 32'd3);
      pll_drop("drop_idle");

      // Lock loss with a request outstanding: abandoned, no underflow afterwards.
      scan(3 * HT + 706);
      chk1("pending_before_drop", line_req, 1'b1);
      pll_drop("drop_pending");
      scan(2 * HT);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
